// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, configurable stop bits.
// TXout and busy are registered and change on the same edges as the FSM.
module uart_tx #(
    parameter int dataWidth  = 8,
    parameter int stopBits   = 2,
    parameter int clksPerBit = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [dataWidth-1:0] dataIn,
    input  logic                 TXen,
    output logic                 TXout,
    output logic                 busy
);

    localparam int CNT_W = (clksPerBit > 1) ? $clog2(clksPerBit) : 1;
    localparam int IDX_W = (dataWidth  > 1) ? $clog2(dataWidth)  : 1;
    localparam int STP_W = (stopBits   > 1) ? $clog2(stopBits)   : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(clksPerBit - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(dataWidth - 1);
    localparam logic [STP_W-1:0] STP_LAST = STP_W'(stopBits - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state_reg, state_next;
    logic [dataWidth-1:0] shift_reg, shift_next;
    logic [CNT_W-1:0]     cnt_reg,   cnt_next;
    logic [IDX_W-1:0]     idx_reg,   idx_next;
    logic [STP_W-1:0]     stop_reg,  stop_next;
    logic                 tx_reg,    tx_next;
    logic                 busy_reg,  busy_next;
    logic                 bit_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            stop_reg  <= '0;
            tx_reg    <= 1'b1;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            stop_reg  <= stop_next;
            tx_reg    <= tx_next;
            busy_reg  <= busy_next;
        end
    end

    assign bit_done = (cnt_reg == CNT_LAST);

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        stop_next  = stop_reg;

        case (state_reg)
            IDLE: begin
                if (TXen) begin
                    state_next = START;
                    shift_next = dataIn;
                    cnt_next   = '0;
                    idx_next   = '0;
                    stop_next  = '0;
                end
            end
            START: begin
                if (bit_done) begin
                    cnt_next   = '0;
                    state_next = DATA;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_next = '0;
                    if (idx_reg == IDX_LAST) begin
                        state_next = STOP;
                        stop_next  = '0;
                    end else begin
                        shift_next = shift_reg >> 1;
                        idx_next   = idx_reg + IDX_W'(1);
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_done) begin
                    cnt_next = '0;
                    if (stop_reg == STP_LAST) begin
                        state_next = IDLE;
                    end else begin
                        stop_next = stop_reg + STP_W'(1);
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are precomputed from the next state so the line flops switch
    // on the very edge that changes state, with no extra cycle of latency.
    always_comb begin
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
        busy_next = (state_next != IDLE);
    end

    assign TXout = tx_reg;
    assign busy  = busy_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: default configuration plus a 7-bit, 1-stop,
// 4-clock-per-bit instance, with expected line values derived per cycle.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [7:0] data_a = '0;
    logic       en_a   = 1'b0;
    logic       tx_a;
    logic       busy_a;

    logic [6:0] data_b = '0;
    logic       en_b   = 1'b0;
    logic       tx_b;
    logic       busy_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx dut_a (
        .clk    (clk),
        .rst    (rst),
        .dataIn (data_a),
        .TXen   (en_a),
        .TXout  (tx_a),
        .busy   (busy_a)
    );

    uart_tx #(
        .dataWidth  (7),
        .stopBits   (1),
        .clksPerBit (4)
    ) dut_b (
        .clk    (clk),
        .rst    (rst),
        .dataIn (data_b),
        .TXen   (en_b),
        .TXout  (tx_b),
        .busy   (busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a frame on instance sel, then checks every cycle of it and the
    // idle cycle that follows. TXen is dropped after `hold` cycles; when
    // scramble is set, dataIn is overwritten right after the accept edge.
    task automatic run_frame(input string tag, input int sel, input logic [15:0] data,
                             input int w, input int s, input int c,
                             input int hold, input bit scramble);
        int len;
        int b;
        logic exp_tx;
        int busy_cycles;
        len = (1 + w + s) * c;
        busy_cycles = 0;
        if (sel == 0) begin
            data_a = data[7:0];
            en_a = 1'b1;
        end else begin
            data_b = data[6:0];
            en_b = 1'b1;
        end
        tick();
        for (int k = 0; k < len; k++) begin
            b = k / c;
            if (b == 0)      exp_tx = 1'b0;
            else if (b <= w) exp_tx = data[b-1];
            else             exp_tx = 1'b1;
            check($sformatf("%s k=%0d tx", tag, k), (sel == 0) ? tx_a : tx_b, exp_tx);
            check($sformatf("%s k=%0d busy", tag, k), (sel == 0) ? busy_a : busy_b, 1);
            if ((sel == 0) ? busy_a : busy_b) busy_cycles++;
            if (k + 1 == hold) begin
                if (sel == 0) en_a = 1'b0; else en_b = 1'b0;
            end
            if (scramble && k == 0) begin
                if (sel == 0) data_a = 8'hFF; else data_b = 7'h7F;
            end
            tick();
        end
        check($sformatf("%s busy_cycles", tag), busy_cycles, len);
        check($sformatf("%s idle tx", tag), (sel == 0) ? tx_a : tx_b, 1);
        check($sformatf("%s idle busy", tag), (sel == 0) ? busy_a : busy_b, 0);
        $display("frame %s data=%0h len=%0d done", tag, data, len);
    endtask

    initial begin
        // Reset held through the first edges
        tick();
        check("reset tx_a", tx_a, 1);
        check("reset busy_a", busy_a, 0);
        check("reset tx_b", tx_b, 1);
        check("reset busy_b", busy_b, 0);
        tick();
        rst = 1'b0;
        tick();
        check("post-reset tx_a", tx_a, 1);
        check("post-reset busy_a", busy_a, 0);

        // Basic frame 0x70, TXen high for 2 cycles, dataIn changed after accept
        run_frame("basic", 0, 16'h0070, 8, 2, 1, 2, 1'b1);
        tick();
        check("basic stays idle tx", tx_a, 1);
        check("basic stays idle busy", busy_a, 0);

        // Back-to-back frames with TXen held high throughout
        run_frame("b2b_1", 0, 16'h00A5, 8, 2, 1, 1000, 1'b0);
        run_frame("b2b_2", 0, 16'h00A5, 8, 2, 1, 1000, 1'b0);
        en_a = 1'b0;
        tick();

        // Reset asserted mid-clock during data bit 3 of a frame
        data_a = 8'h70;
        en_a = 1'b1;
        tick();
        en_a = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("pre-midreset busy", busy_a, 1);
        #3;
        rst = 1'b1;
        #1;
        check("midreset tx immediate", tx_a, 1);
        check("midreset busy immediate", busy_a, 0);
        tick();
        tick();
        check("midreset tx held", tx_a, 1);
        check("midreset busy held", busy_a, 0);
        rst = 1'b0;
        tick();
        check("after midreset busy", busy_a, 0);
        run_frame("after_rst", 0, 16'h00C3, 8, 2, 1, 1, 1'b0);

        // Parameter sweep instance
        run_frame("sweep", 1, 16'h0055, 7, 1, 4, 1, 1'b1);
        tick();
        check("sweep stays idle busy", busy_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
